// File: rtl/fetch_decode_reg_pkg.sv
// Shared definitions for the IF/ID pipeline boundary: state encoding (matches the
// fetch FSM) and the bubble instruction word.
package fetch_decode_reg_pkg;

  localparam logic [31:0] NOP_WORD = 32'd0;

  typedef enum logic {
    NORMAL   = 1'b0,
    WAIT_IMM = 1'b1
  } fd_state_e;

endpackage

// File: rtl/fetch_decode_reg_if.sv
// Fetch-to-decode bundle: the fetch side (master) drives words and hazard controls,
// the pipeline register (slave) returns the decode packet and its busy flag.
interface fetch_decode_reg_if #(
  parameter int DATAWIDTH = 32
) ();

  logic                 stall;
  logic                 flush;
  logic                 extend;
  logic [DATAWIDTH-1:0] pc_in;
  logic [DATAWIDTH-1:0] instr_in;
  logic                 valid_out;
  logic [DATAWIDTH-1:0] pc_out;
  logic [DATAWIDTH-1:0] instr_out;
  logic [DATAWIDTH-1:0] imm_out;
  logic                 ext_out;
  logic                 busy;

  modport master (
    output stall, flush, extend, pc_in, instr_in,
    input  valid_out, pc_out, instr_out, imm_out, ext_out, busy
  );

  modport slave (
    input  stall, flush, extend, pc_in, instr_in,
    output valid_out, pc_out, instr_out, imm_out, ext_out, busy
  );

endinterface

// File: rtl/fetch_decode_reg_pipe_reg.sv
// Single pipeline register word: async reset, hold when not enabled, and a
// synchronous clear that overrides the enable so a flush always lands.
module pipe_reg #(
  parameter int                   WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (clr) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register: latches fetched words for decode, merging a two-word
// extended instruction (opcode + 32-bit immediate) into a single packet.
module fetch_decode_reg
  import fetch_decode_reg_pkg::*;
#(
  parameter int                   DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0] NOP       = DATAWIDTH'(NOP_WORD)
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_decode_reg_if.slave     bus
);

  fd_state_e            state_q;
  logic [DATAWIDTH-1:0] hold_pc_q;
  logic [DATAWIDTH-1:0] hold_instr_q;
  logic                 valid_q;
  logic                 ext_q;

  logic [DATAWIDTH-1:0] pc_d;
  logic [DATAWIDTH-1:0] instr_d;
  logic [DATAWIDTH-1:0] imm_d;
  logic [DATAWIDTH-1:0] pc_q;
  logic [DATAWIDTH-1:0] instr_q;
  logic [DATAWIDTH-1:0] imm_q;
  logic                 capEn;

  assign capEn = ~bus.stall;

  // During the bubble for a first word, pc_out keeps its old value; only the
  // opcode slot is forced to NOP so decode sees a harmless instruction.
  always_comb begin
    pc_d    = pc_q;
    instr_d = NOP;
    imm_d   = '0;
    if (state_q == WAIT_IMM) begin
      pc_d    = hold_pc_q;
      instr_d = hold_instr_q;
      imm_d   = bus.instr_in;
    end else if (!bus.extend) begin
      pc_d    = bus.pc_in;
      instr_d = bus.instr_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= NORMAL;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      valid_q      <= 1'b0;
      ext_q        <= 1'b0;
    end else if (bus.flush) begin
      state_q      <= NORMAL;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      valid_q      <= 1'b0;
      ext_q        <= 1'b0;
    end else if (!bus.stall) begin
      case (state_q)
        NORMAL: begin
          if (bus.extend) begin
            hold_pc_q    <= bus.pc_in;
            hold_instr_q <= bus.instr_in;
            valid_q      <= 1'b0;
            ext_q        <= 1'b0;
            state_q      <= WAIT_IMM;
          end else begin
            valid_q <= 1'b1;
            ext_q   <= 1'b0;
          end
        end
        WAIT_IMM: begin
          valid_q <= 1'b1;
          ext_q   <= 1'b1;
          state_q <= NORMAL;
        end
        default: begin
          state_q <= NORMAL;
        end
      endcase
    end
  end

  pipe_reg #(.WIDTH(DATAWIDTH), .RESET_VAL('0)) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (capEn),
    .clr (bus.flush),
    .d   (pc_d),
    .q   (pc_q)
  );

  pipe_reg #(.WIDTH(DATAWIDTH), .RESET_VAL(NOP)) u_instr_reg (
    .clk (clk),
    .rst (rst),
    .en  (capEn),
    .clr (bus.flush),
    .d   (instr_d),
    .q   (instr_q)
  );

  pipe_reg #(.WIDTH(DATAWIDTH), .RESET_VAL('0)) u_imm_reg (
    .clk (clk),
    .rst (rst),
    .en  (capEn),
    .clr (bus.flush),
    .d   (imm_d),
    .q   (imm_q)
  );

  // busy is deliberately unregistered so fetch sees it in the same cycle.
  assign bus.busy      = (state_q == WAIT_IMM);
  assign bus.valid_out = valid_q;
  assign bus.ext_out   = ext_q;
  assign bus.pc_out    = pc_q;
  assign bus.instr_out = instr_q;
  assign bus.imm_out   = imm_q;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Self-checking bench for fetch_decode_reg: directed vectors, a queue-based
// reference model compared every cycle, and literal spot checks.
module tb_fetch_decode_reg;

  localparam logic [31:0] NOP = 32'd0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } word_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   compareEn;

  fetch_decode_reg_if #(.DATAWIDTH(32)) tif ();

  fetch_decode_reg #(.DATAWIDTH(32), .NOP(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a pending first word lives in a queue until its immediate arrives.
  word_t       pendQ[$];
  logic        mValid;
  logic        mExt;
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mImm;

  always @(posedge clk or posedge rst) begin
    if (rst || tif.flush) begin
      pendQ.delete();
      mValid = 1'b0;
      mExt   = 1'b0;
      mPc    = 32'd0;
      mInstr = NOP;
      mImm   = 32'd0;
    end else if (!tif.stall) begin
      if (pendQ.size() != 0) begin
        mValid = 1'b1;
        mExt   = 1'b1;
        mPc    = pendQ[0].pc;
        mInstr = pendQ[0].instr;
        mImm   = tif.instr_in;
        pendQ.pop_front();
      end else if (tif.extend) begin
        pendQ.push_back({tif.pc_in, tif.instr_in});
        mValid = 1'b0;
        mExt   = 1'b0;
        mInstr = NOP;
      end else begin
        mValid = 1'b1;
        mExt   = 1'b0;
        mPc    = tif.pc_in;
        mInstr = tif.instr_in;
        mImm   = 32'd0;
      end
    end
  end

  task automatic compareVal(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%08h want 0x%08h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (compareEn) begin
      compareVal("mon_valid", 32'(tif.valid_out), 32'(mValid));
      compareVal("mon_ext", 32'(tif.ext_out), 32'(mExt));
      compareVal("mon_busy", 32'(tif.busy), 32'(pendQ.size() != 0));
      compareVal("mon_instr", tif.instr_out, mInstr);
      if (mValid) begin
        compareVal("mon_pc", tif.pc_out, mPc);
        compareVal("mon_imm", tif.imm_out, mImm);
      end
    end
  end

  task automatic applyStimulus(input logic st, input logic fl, input logic ex,
                               input logic [31:0] pc, input logic [31:0] ins);
    @(negedge clk);
    tif.stall    = st;
    tif.flush    = fl;
    tif.extend   = ex;
    tif.pc_in    = pc;
    tif.instr_in = ins;
  endtask

  task automatic checkOutput(input string name, input logic valid, input logic ext,
                             input logic busy, input logic [31:0] instr, input bit checkData,
                             input logic [31:0] pc, input logic [31:0] imm);
    compareVal({name, "_valid"}, 32'(tif.valid_out), 32'(valid));
    compareVal({name, "_ext"}, 32'(tif.ext_out), 32'(ext));
    compareVal({name, "_busy"}, 32'(tif.busy), 32'(busy));
    compareVal({name, "_instr"}, tif.instr_out, instr);
    if (checkData) begin
      compareVal({name, "_pc"}, tif.pc_out, pc);
      compareVal({name, "_imm"}, tif.imm_out, imm);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    compareEn    = 1'b0;
    rst          = 1'b0;
    tif.stall    = 1'b0;
    tif.flush    = 1'b0;
    tif.extend   = 1'b0;
    tif.pc_in    = 32'd0;
    tif.instr_in = 32'd0;

    #3  rst = 1'b1;
    #8  checkOutput("reset", 1'b0, 1'b0, 1'b0, NOP, 1'b1, 32'd0, 32'd0);
    #1  rst = 1'b0;
    compareEn = 1'b1;

    // Plain words, one cycle latency each.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h11111111);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h4, 32'h22222222);
    checkOutput("plain0", 1'b1, 1'b0, 1'b0, 32'h11111111, 1'b1, 32'h0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h8, 32'h33333333);
    checkOutput("plain1", 1'b1, 1'b0, 1'b0, 32'h22222222, 1'b1, 32'h4, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("plain2", 1'b1, 1'b0, 1'b0, 32'h33333333, 1'b1, 32'h8, 32'd0);

    // Two-word instruction: bubble then merged packet.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h10, 32'hA0000001);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h14, 32'hDEADBEEF);
    checkOutput("ext_bubble", 1'b0, 1'b0, 1'b1, NOP, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("ext_pkt", 1'b1, 1'b1, 1'b0, 32'hA0000001, 1'b1, 32'h10, 32'hDEADBEEF);

    // Stall three cycles while waiting for the immediate.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 32'hB0000002);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h24, 32'hFFFFFFFF);
      checkOutput("stall_wait", 1'b0, 1'b0, 1'b1, NOP, 1'b0, 32'd0, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h24, 32'h12345678);
    checkOutput("stall_hold", 1'b0, 1'b0, 1'b1, NOP, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("stall_pkt", 1'b1, 1'b1, 1'b0, 32'hB0000002, 1'b1, 32'h20, 32'h12345678);

    // Flush while waiting for the immediate, then a plain word.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h30, 32'hC0000003);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h34, 32'h99999999);
    checkOutput("flush_pre", 1'b0, 1'b0, 1'b1, NOP, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h40, 32'h44444444);
    checkOutput("flush_post", 1'b0, 1'b0, 1'b0, NOP, 1'b1, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("after_flush", 1'b1, 1'b0, 1'b0, 32'h44444444, 1'b1, 32'h40, 32'd0);

    // Flush and stall together on a held valid packet.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h44, 32'h55555555);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("flush_stall", 1'b0, 1'b0, 1'b0, NOP, 1'b1, 32'd0, 32'd0);

    // Async reset while mid-assembly.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h50, 32'hD0000005);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("busy_pre_rst", 1'b0, 1'b0, 1'b1, NOP, 1'b0, 32'd0, 32'd0);
    #2 rst = 1'b1;
    #1 checkOutput("async_rst", 1'b0, 1'b0, 1'b0, NOP, 1'b1, 32'd0, 32'd0);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h54, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("post_rst", 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h54, 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h58, 32'h66666666);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h5C, 32'h77777777);
    checkOutput("final", 1'b1, 1'b0, 1'b0, 32'h66666666, 1'b1, 32'h58, 32'd0);
    @(negedge clk);
    compareEn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
